// File: rtl/icache_pkg.sv
// ============================================================================
//  Module      : icache_pkg
//  Description : Shared types, constants and FSM encoding for the icache.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_pkg;

    localparam int ADDR_W         = 32;
    localparam int WORD_BITS      = 32;

    typedef logic [ADDR_W-1:0]    ADDR_TP;
    typedef logic [WORD_BITS-1:0] WORD_TP;

    localparam logic   TRUE      = 1'b1;
    localparam logic   FALSE     = 1'b0;
    localparam ADDR_TP ZERO_ADDR = '0;

    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_SET_NUM    = 64;

    localparam int ICACHE_WORD_W  = $clog2(DEF_LINE_WORDS);
    localparam int ICACHE_IDX_W   = $clog2(DEF_SET_NUM);
    localparam int ICACHE_TAG_W   = ADDR_W - 2 - ICACHE_WORD_W - ICACHE_IDX_W;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } icache_state_e;

endpackage

`default_nettype wire

// File: rtl/icache_refill.sv
// ============================================================================
//  Module      : icache_refill
//  Description : Refill FSM, word counter, fill mask, deferred invalidate and
//                memory request handshake for the icache.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_refill
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int IDX_W      = ICACHE_IDX_W,
    parameter int WORD_W     = ICACHE_WORD_W,
    parameter int TAG_W      = ICACHE_TAG_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  miss,
    input  logic                  inv,
    input  logic [TAG_W-1:0]      rd_tag,
    input  logic [IDX_W-1:0]      rd_idx,
    input  logic                  mem_vld,
    output logic                  mem_req,
    output ADDR_TP                mem_addr,
    output logic                  refilling,
    output logic [TAG_W-1:0]      rtag,
    output logic [IDX_W-1:0]      ridx,
    output logic [WORD_W-1:0]     cnt,
    output logic [LINE_WORDS-1:0] fill_mask,
    output logic                  inv_pend,
    output logic                  start_fill,
    output logic                  wr_word,
    output logic                  done_fill,
    output logic                  clr_all
);

    localparam logic [WORD_W-1:0] C_LAST_WORD = WORD_W'(LINE_WORDS - 1);

    icache_state_e         r_state;
    icache_state_e         w_state_n;
    logic [WORD_W-1:0]     r_cnt;
    logic [WORD_W-1:0]     w_cnt_n;
    logic [LINE_WORDS-1:0] r_fill_mask;
    logic [LINE_WORDS-1:0] w_fill_mask_n;
    logic                  r_inv_pend;
    logic                  w_inv_pend_n;
    logic [TAG_W-1:0]      r_rtag;
    logic [TAG_W-1:0]      w_rtag_n;
    logic [IDX_W-1:0]      r_ridx;
    logic [IDX_W-1:0]      w_ridx_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_fill_mask <= '0;
            r_inv_pend  <= FALSE;
            r_rtag      <= '0;
            r_ridx      <= '0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_fill_mask <= w_fill_mask_n;
            r_inv_pend  <= w_inv_pend_n;
            r_rtag      <= w_rtag_n;
            r_ridx      <= w_ridx_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_fill_mask_n = r_fill_mask;
        w_inv_pend_n  = r_inv_pend;
        w_rtag_n      = r_rtag;
        w_ridx_n      = r_ridx;
        start_fill    = FALSE;
        wr_word       = FALSE;
        done_fill     = FALSE;
        clr_all       = FALSE;
        mem_req       = FALSE;
        mem_addr      = ZERO_ADDR;
        case (r_state)
            ST_IDLE: begin
                if (rdy) begin
                    // A deferred invalidate lands here, covering the line just refilled.
                    if (inv || r_inv_pend) begin
                        clr_all      = TRUE;
                        w_inv_pend_n = FALSE;
                    end
                    if (miss) begin
                        start_fill = TRUE;
                        w_rtag_n   = rd_tag;
                        w_ridx_n   = rd_idx;
                        w_cnt_n    = '0;
                        w_state_n  = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                mem_req  = TRUE;
                mem_addr = {r_rtag, r_ridx, r_cnt, 2'b00};
                if (rdy) begin
                    if (inv) begin
                        w_inv_pend_n = TRUE;
                    end
                    if (mem_vld) begin
                        wr_word              = TRUE;
                        w_fill_mask_n[r_cnt] = TRUE;
                        w_cnt_n              = r_cnt + 1'b1;
                        if (r_cnt == C_LAST_WORD) begin
                            done_fill     = TRUE;
                            w_fill_mask_n = '0;
                            w_state_n     = ST_IDLE;
                        end
                    end
                end
            end
        endcase
    end

    assign refilling = (r_state == ST_REFILL);
    assign rtag      = r_rtag;
    assign ridx      = r_ridx;
    assign cnt       = r_cnt;
    assign fill_mask = r_fill_mask;
    assign inv_pend  = r_inv_pend;

endmodule

`default_nettype wire

// File: rtl/icache.sv
// ============================================================================
//  Module      : icache
//  Description : Direct-mapped instruction cache with combinational lookup,
//                word-serial line refill and hit-under-miss. Optional
//                critical-word forwarding is enabled by ICACHE_CWF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int SET_NUM    = DEF_SET_NUM
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rd_en,
    input  logic [31:0] rd_addr,
    output logic        hit,
    output logic [31:0] hit_inst,
    input  logic        inv,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_vld,
    input  logic [31:0] mem_data
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SET_NUM);
    localparam int TAG_W  = ADDR_W - 2 - WORD_W - IDX_W;

`ifdef ICACHE_CWF_EN
    localparam logic C_CWF_EN = TRUE;
`else
    localparam logic C_CWF_EN = FALSE;
`endif

    logic [SET_NUM-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag  [SET_NUM];
    WORD_TP             r_data [SET_NUM][LINE_WORDS];

    logic [WORD_W-1:0]     w_word;
    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_unused_byte;
    logic                  w_hit_resident;
    logic                  w_hit_fwd;
    logic                  w_hit;
    logic                  w_miss;

    logic                  w_refilling;
    logic [TAG_W-1:0]      w_rtag;
    logic [IDX_W-1:0]      w_ridx;
    logic [WORD_W-1:0]     w_cnt;
    logic [LINE_WORDS-1:0] w_fill_mask;
    logic                  w_inv_pend;
    logic                  w_start_fill;
    logic                  w_wr_word;
    logic                  w_done_fill;
    logic                  w_clr_all;

    assign w_word        = rd_addr[WORD_W+1:2];
    assign w_idx         = rd_addr[WORD_W+IDX_W+1:WORD_W+2];
    assign w_tag         = rd_addr[ADDR_W-1:WORD_W+IDX_W+2];
    assign w_unused_byte = ^rd_addr[1:0];

    assign w_hit_resident = rd_en && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // The refilling line has its valid bit cleared, so it can only hit through the fill mask.
    assign w_hit_fwd      = rd_en && w_refilling && (w_tag == w_rtag) &&
                            (w_idx == w_ridx) && w_fill_mask[w_word];
    assign w_hit          = !w_inv_pend && (w_hit_resident || (C_CWF_EN && w_hit_fwd));
    assign w_miss         = rd_en && !w_hit;

    assign hit      = w_hit;
    assign hit_inst = w_hit ? r_data[w_idx][w_word] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            if (w_clr_all) begin
                r_valid <= '0;
            end
            if (w_start_fill) begin
                r_valid[w_idx] <= FALSE;
            end
            if (w_done_fill) begin
                r_valid[w_ridx] <= TRUE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_done_fill) begin
            r_tag[w_ridx] <= w_rtag;
        end
        if (w_wr_word) begin
            r_data[w_ridx][w_cnt] <= mem_data;
        end
    end

    icache_refill #(
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W),
        .WORD_W     (WORD_W),
        .TAG_W      (TAG_W)
    ) u_refill (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .miss       (w_miss),
        .inv        (inv),
        .rd_tag     (w_tag),
        .rd_idx     (w_idx),
        .mem_vld    (mem_vld),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .refilling  (w_refilling),
        .rtag       (w_rtag),
        .ridx       (w_ridx),
        .cnt        (w_cnt),
        .fill_mask  (w_fill_mask),
        .inv_pend   (w_inv_pend),
        .start_fill (w_start_fill),
        .wr_word    (w_wr_word),
        .done_fill  (w_done_fill),
        .clr_all    (w_clr_all)
    );

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
//  Module      : tb_icache
//  Description : Scoreboard bench for icache; lookups and refill addresses are
//                queued as expectations and checked by a monitor process.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        rdy      = 1'b1;
    logic        rd_en    = 1'b0;
    logic [31:0] rd_addr  = '0;
    logic        inv      = 1'b0;
    logic        mem_vld  = 1'b0;
    logic [31:0] mem_data = '0;
    logic        hit;
    logic [31:0] hit_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        probe    = 1'b0;

    typedef struct {
        logic        hit;
        logic [31:0] inst;
    } look_t;

    look_t       look_q[$];
    logic [31:0] addr_q[$];
    int          checks = 0;
    int          errors = 0;

`ifdef ICACHE_CWF_EN
    localparam logic CWF = 1'b1;
`else
    localparam logic CWF = 1'b0;
`endif

    always #5 clk = ~clk;

    icache dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .hit      (hit),
        .hit_inst (hit_inst),
        .inv      (inv),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_vld  (mem_vld),
        .mem_data (mem_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: lookups flagged by probe, and every accepted refill word.
    always @(negedge clk) begin
        if (probe) begin
            if (look_q.size() == 0) begin
                check("lookup_queue_empty", 32'd1, 32'd0);
            end else begin
                look_t e;
                e = look_q.pop_front();
                check("hit", {31'b0, hit}, {31'b0, e.hit});
                check("hit_inst", hit_inst, e.inst);
            end
        end
        if (!rst && rdy && mem_req && mem_vld) begin
            if (addr_q.size() == 0) begin
                check("mem_addr_unexpected", mem_addr, 32'hFFFF_FFFF);
            end else begin
                check("mem_addr", mem_addr, addr_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] a, input logic eh, input logic [31:0] ei);
        look_t e;
        e.hit  = eh;
        e.inst = ei;
        look_q.push_back(e);
        rd_en   = 1'b1;
        rd_addr = a;
        probe   = 1'b1;
        cyc();
        rd_en = 1'b0;
        probe = 1'b0;
    endtask

    task automatic expect_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            addr_q.push_back(base + 32'(4 * i));
        end
    endtask

    task automatic word(input int gap);
        repeat (gap) cyc();
        mem_vld  = 1'b1;
        mem_data = {16'hC0DE, mem_addr[15:0]};
        cyc();
        mem_vld = 1'b0;
    endtask

    task automatic fill(input int gap);
        for (int i = 0; i < 4; i++) begin
            word(gap);
        end
    endtask

    initial begin
        repeat (3) cyc();
        rst = 1'b0;
        #0;
        check("rst_hit", {31'b0, hit}, 32'd0);
        check("rst_hit_inst", hit_inst, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);

        // Cold miss with 2-cycle gaps between returned words.
        expect_line(32'h0000_0010);
        lookup(32'h0000_0010, 1'b0, 32'h0);
        check("miss_req_next_cycle", {31'b0, mem_req}, 32'd1);
        fill(2);
        lookup(32'h0000_0010, 1'b1, 32'hC0DE_0010);
        check("req_low_after_fill", {31'b0, mem_req}, 32'd0);
        lookup(32'h0000_0014, 1'b1, 32'hC0DE_0014);
        check("req_low_after_hit", {31'b0, mem_req}, 32'd0);

        // Conflict on index 1: 0x410 evicts 0x010.
        expect_line(32'h0000_0410);
        lookup(32'h0000_0410, 1'b0, 32'h0);
        fill(1);
        lookup(32'h0000_0410, 1'b1, 32'hC0DE_0410);
        expect_line(32'h0000_0010);
        lookup(32'h0000_0010, 1'b0, 32'h0);
        fill(0);

        // Hit-under-miss, fill-mask forwarding, inv on the final word.
        expect_line(32'h0000_0100);
        lookup(32'h0000_0100, 1'b0, 32'h0);
        lookup(32'h0000_0010, 1'b1, 32'hC0DE_0010);
        word(1);
        word(1);
        lookup(32'h0000_0104, CWF, CWF ? 32'hC0DE_0104 : 32'h0);
        lookup(32'h0000_0108, 1'b0, 32'h0);
        word(0);
        inv = 1'b1;
        word(0);
        inv = 1'b0;
        expect_line(32'h0000_0010);
        lookup(32'h0000_0010, 1'b0, 32'h0);
        fill(0);

        // 0x100 was dropped by the invalidate; refill with a stalled cycle.
        expect_line(32'h0000_0100);
        lookup(32'h0000_0100, 1'b0, 32'h0);
        word(1);
        rdy      = 1'b0;
        mem_vld  = 1'b1;
        mem_data = 32'hDEAD_BEEF;
        lookup(32'h0000_0010, 1'b1, 32'hC0DE_0010);
        rdy     = 1'b1;
        mem_vld = 1'b0;
        check("stall_holds_addr", mem_addr, 32'h0000_0104);
        word(0);
        word(0);
        word(0);
        lookup(32'h0000_010C, 1'b1, 32'hC0DE_010C);

        // Reset in the middle of a refill.
        addr_q.push_back(32'h0000_0200);
        lookup(32'h0000_0200, 1'b0, 32'h0);
        word(0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_mid_req", {31'b0, mem_req}, 32'd0);
        check("rst_mid_addr", mem_addr, 32'd0);
        expect_line(32'h0000_0010);
        lookup(32'h0000_0010, 1'b0, 32'h0);
        fill(0);
        lookup(32'h0000_0018, 1'b1, 32'hC0DE_0018);

        repeat (3) cyc();
        check("lookup_queue_drained", 32'(look_q.size()), 32'd0);
        check("addr_queue_drained", 32'(addr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
